// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RV32I control path: FSM states,
// opcode constants, ALU operation codes and datapath mux encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_LUI,
        S_EXEC_AUIPC,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_EXEC_JALR,
        S_JALR,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALUOP_ADD    = 4'd0;
    localparam logic [3:0] ALUOP_BRANCH = 4'd1;
    localparam logic [3:0] ALUOP_RTYPE  = 4'd2;
    localparam logic [3:0] ALUOP_ITYPE  = 4'd3;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_LOAD   = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    // First execution state for a decoded opcode; unknown opcodes trap.
    function automatic state_t dispatch(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: dispatch = S_MEMADR;
            OP_RTYPE:          dispatch = S_EXEC_R;
            OP_ITYPE:          dispatch = S_EXEC_I;
            OP_BRANCH:         dispatch = S_BRANCH;
            OP_JAL:            dispatch = S_JAL;
            OP_JALR:           dispatch = S_EXEC_JALR;
            OP_LUI:            dispatch = S_EXEC_LUI;
            OP_AUIPC:          dispatch = S_EXEC_AUIPC;
            default:           dispatch = S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_retire_counter.sv
// Retired-instruction counter: synchronous clear, increment enable,
// wraps modulo 2^CNT_W.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count register; clear takes priority over increment.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (clear)
            count <= '0;
        else if (inc)
            count <= count + ONE;
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM: steps each instruction through
// fetch/decode/execute/memory/writeback, waits on the shared memory port
// handshake and counts retired instructions.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             branch_cond,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_lsb_clear,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state;
    state_t           state_next;
    logic             retire_inc;
    logic [CNT_W-1:0] count;

    // funct3 is consumed by the ALU decoder, not by the sequencer.
    logic unused_funct3;
    assign unused_funct3 = ^funct3;

    // State register; synchronous reset restarts at FETCH.
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= state_next;
    end

    // Next-state and Moore output decode; everything is forced low in reset
    // so a pending memory access is dropped in the same cycle.
    always_comb begin
        // NOTE: every output gets a default before the case so that no
        // state path leaves a signal unassigned and infers a latch.
        state_next   = state;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_lsb_clear = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RS2;
        alu_op       = ALUOP_ADD;
        result_src   = RES_ALUOUT;
        illegal      = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                    if (mem_ready)
                        state_next = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_IMM;
                    state_next = dispatch(opcode);
                end
                S_MEMADR: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready)
                        state_next = S_MEMWB;
                end
                S_MEMWB: begin
                    result_src = RES_LOAD;
                    reg_write  = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    if (mem_ready)
                        state_next = S_FETCH;
                end
                S_EXEC_R: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    alu_op     = ALUOP_RTYPE;
                    state_next = S_ALUWB;
                end
                S_EXEC_I: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    alu_op     = ALUOP_ITYPE;
                    state_next = S_ALUWB;
                end
                S_EXEC_LUI: begin
                    alu_src_a  = SRCA_ZERO;
                    alu_src_b  = SRCB_IMM;
                    state_next = S_ALUWB;
                end
                S_EXEC_AUIPC: begin
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_IMM;
                    state_next = S_ALUWB;
                end
                S_ALUWB: begin
                    result_src = RES_ALUOUT;
                    reg_write  = 1'b1;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    alu_op     = ALUOP_BRANCH;
                    result_src = RES_ALUOUT;
                    pc_write   = branch_cond;
                    state_next = S_FETCH;
                end
                S_JAL: begin
                    // PC takes the target held in ALUOut while the ALU
                    // forms the link value OldPC+4.
                    result_src = RES_ALUOUT;
                    pc_write   = 1'b1;
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    state_next = S_ALUWB;
                end
                S_EXEC_JALR: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    state_next = S_JALR;
                end
                S_JALR: begin
                    result_src   = RES_ALUOUT;
                    pc_write     = 1'b1;
                    pc_lsb_clear = 1'b1;
                    alu_src_a    = SRCA_OLDPC;
                    alu_src_b    = SRCB_FOUR;
                    state_next   = S_ALUWB;
                end
                S_TRAP: begin
                    illegal    = 1'b1;
                    state_next = S_TRAP;
                end
                default: state_next = S_FETCH;
            endcase
        end
    end

    // An instruction retires whenever the FSM re-enters FETCH.
    assign retire_inc = !reset && (state != S_FETCH) && (state_next == S_FETCH);

    retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
        .clk   (clk),
        .clear (reset),
        .inc   (retire_inc),
        .count (count)
    );

    assign retired = reset ? '0 : count;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: randomized instruction
// stream and memory stalls against a per-instruction step-sequence model.
module tb_multicycle_controller;
    import mc_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             branch_cond;
    logic             mem_ready;
    logic             mem_req, mem_write, adr_src, ir_write, pc_write;
    logic             pc_lsb_clear, reg_write, illegal;
    logic [1:0]       alu_src_a, alu_src_b, result_src;
    logic [3:0]       alu_op;
    logic [CNT_W-1:0] retired;

    int n_compared   = 0;
    int n_mismatched = 0;
    int model_retired = 0;

    typedef enum {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
        P_EXR, P_EXI, P_LUI, P_AUIPC, P_ALUWB, P_BRANCH, P_JAL,
        P_EXJALR, P_JALR, P_TRAP
    } phase_t;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct3       (funct3),
        .branch_cond  (branch_cond),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_write    (mem_write),
        .adr_src      (adr_src),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_lsb_clear (pc_lsb_clear),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .result_src   (result_src),
        .illegal      (illegal),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [17:0] ctrl_vec();
        return {mem_req, mem_write, adr_src, ir_write, pc_write, pc_lsb_clear,
                reg_write, alu_src_a, alu_src_b, alu_op, result_src, illegal};
    endfunction

    // Expected control word for one step of an instruction.
    function automatic logic [17:0] exp_ctrl(input phase_t ph, input logic rdy, input logic bc);
        logic       mreq = 0, mwr = 0, adr = 0, irw = 0, pcw = 0, lsb = 0, rw = 0, ill = 0;
        logic [1:0] a = 0, b = 0, rs = 0;
        logic [3:0] op = ALUOP_ADD;
        case (ph)
            P_FETCH:    begin mreq = 1; b = 2; rs = 2; irw = rdy; pcw = rdy; end
            P_DECODE:   begin a = 1; b = 1; end
            P_MEMADR:   begin a = 2; b = 1; end
            P_MEMREAD:  begin mreq = 1; adr = 1; end
            P_MEMWB:    begin rs = 1; rw = 1; end
            P_MEMWRITE: begin mreq = 1; mwr = 1; adr = 1; end
            P_EXR:      begin a = 2; b = 0; op = ALUOP_RTYPE; end
            P_EXI:      begin a = 2; b = 1; op = ALUOP_ITYPE; end
            P_LUI:      begin a = 3; b = 1; end
            P_AUIPC:    begin a = 1; b = 1; end
            P_ALUWB:    begin rw = 1; end
            P_BRANCH:   begin a = 2; b = 0; op = ALUOP_BRANCH; pcw = bc; end
            P_JAL:      begin pcw = 1; a = 1; b = 2; end
            P_EXJALR:   begin a = 2; b = 1; end
            P_JALR:     begin pcw = 1; lsb = 1; a = 1; b = 2; end
            P_TRAP:     begin ill = 1; end
            default:    ;
        endcase
        return {mreq, mwr, adr, irw, pcw, lsb, rw, a, b, op, rs, ill};
    endfunction

    // Hold reset for n cycles; everything must read zero meanwhile. Reset is
    // released by the next instruction's first step.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset     = 1'b1;
            mem_ready = 1'(($urandom % 2));
            #1;
            check("reset_ctrl", 32'(ctrl_vec()), 32'd0);
            check("reset_retired", 32'(retired), 32'd0);
        end
        model_retired = 0;
    endtask

    // Run one instruction. fst/mst: cycles of mem_ready low in the fetch and
    // data access. abort_after > 0 stops after that many cycles (no retire).
    task automatic run_instr(input logic [6:0] op, input logic bc,
                             input int fst, input int mst, input int abort_after);
        phase_t seq[$];
        int     idx = 0;
        int     cyc = 0;
        logic   retires = 1'b1;
        case (op)
            7'b0000011: seq = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB};
            7'b0100011: seq = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMWRITE};
            7'b0110011: seq = '{P_FETCH, P_DECODE, P_EXR, P_ALUWB};
            7'b0010011: seq = '{P_FETCH, P_DECODE, P_EXI, P_ALUWB};
            7'b1100011: seq = '{P_FETCH, P_DECODE, P_BRANCH};
            7'b1101111: seq = '{P_FETCH, P_DECODE, P_JAL, P_ALUWB};
            7'b1100111: seq = '{P_FETCH, P_DECODE, P_EXJALR, P_JALR, P_ALUWB};
            7'b0110111: seq = '{P_FETCH, P_DECODE, P_LUI, P_ALUWB};
            7'b0010111: seq = '{P_FETCH, P_DECODE, P_AUIPC, P_ALUWB};
            default: begin
                seq = '{P_FETCH, P_DECODE};
                for (int i = 0; i < 10; i++) seq.push_back(P_TRAP);
                retires = 1'b0;
            end
        endcase
        opcode      = op;
        funct3      = 3'($urandom);
        branch_cond = bc;
        while (idx < seq.size()) begin
            phase_t ph;
            logic   memph;
            if (abort_after > 0 && cyc == abort_after) return;
            ph    = seq[idx];
            memph = (ph == P_FETCH) || (ph == P_MEMREAD) || (ph == P_MEMWRITE);
            @(negedge clk);
            reset = 1'b0;
            if (ph == P_FETCH) begin
                mem_ready = (fst == 0);
                if (fst > 0) fst--;
            end else if (memph) begin
                mem_ready = (mst == 0);
                if (mst > 0) mst--;
            end else begin
                mem_ready = 1'(($urandom % 2));
            end
            #1;
            check($sformatf("ctrl op=%b step=%0d", op, idx), 32'(ctrl_vec()),
                  32'(exp_ctrl(ph, mem_ready, bc)));
            check("retired", 32'(retired), 32'(model_retired));
            cyc++;
            if (!(memph && !mem_ready)) idx++;
        end
        if (retires) model_retired = (model_retired + 1) % (1 << CNT_W);
    endtask

    logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                  7'b0010111};

    initial begin
        reset       = 1'b1;
        mem_ready   = 1'b0;
        opcode      = '0;
        funct3      = '0;
        branch_cond = 1'b0;

        do_reset(3);
        run_instr(7'b0110011, 1'b0, 0, 0, 0);   // R-type straight out of reset
        run_instr(7'b0000011, 1'b0, 0, 3, 0);   // load, 3 stall cycles in MEMREAD
        run_instr(7'b1100011, 1'b1, 0, 0, 0);   // branch taken
        run_instr(7'b1100011, 1'b0, 0, 0, 0);   // branch not taken
        run_instr(7'b1100111, 1'b0, 0, 0, 0);   // JALR
        run_instr(7'b1101111, 1'b0, 2, 0, 0);   // JAL with fetch stalls
        run_instr(7'b0100011, 1'b0, 1, 2, 0);   // store with stalls
        run_instr(7'b0110111, 1'b0, 0, 0, 0);   // LUI
        run_instr(7'b0010111, 1'b0, 0, 0, 0);   // AUIPC
        run_instr(7'b0010011, 1'b0, 0, 0, 0);   // I-type

        // Illegal opcode: trap, then reset recovers.
        run_instr(7'b1111111, 1'b0, 0, 0, 0);
        do_reset(2);
        run_instr(7'b0110011, 1'b0, 0, 0, 0);

        // Reset while a store is waiting on memory.
        run_instr(7'b0100011, 1'b0, 0, 100, 5);
        do_reset(1);
        run_instr(7'b0010011, 1'b0, 0, 0, 0);

        // Counter wrap: 16 more retirements from 1 passes through 15 -> 0.
        for (int i = 0; i < 16; i++)
            run_instr(legal_ops[$urandom_range(0, 8)], 1'($urandom % 2), 0, 0, 0);

        // Random mix with random stalls and an occasional trap.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                run_instr(7'b1111111 ^ 7'($urandom_range(0, 3) << 3), 1'b0, 0, 0, 0);
                do_reset($urandom_range(1, 2));
            end else begin
                run_instr(legal_ops[$urandom_range(0, 8)], 1'($urandom % 2),
                          $urandom_range(0, 3), $urandom_range(0, 3), 0);
            end
        end
        run_instr(7'b0110011, 1'b0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing control FSM for the multicycle RV32I datapath variant. It replaces the single-cycle control unit and its hard-wired PC update path. The datapath shares one memory port for fetch and data, and its ALU is reused for PC+4, branch targets and address generation. This block steps each instruction through fetch/decode/execute/memory/writeback states, waits on the memory handshake, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  7  instruction register bits [6:0]
- funct3  in  3  instruction register bits [14:12], passed through for ALU decode
- branch_cond  in  1  branch condition true, from jump-control logic, valid in BRANCH
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  store strobe, qualified by mem_req
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR and OldPC
- pc_write  out  1  load PC from the result bus
- pc_lsb_clear  out  1  force bit 0 of the new PC to 0 (JALR)
- reg_write  out  1  register file write enable
- alu_src_a  out  2  0 = PC, 1 = OldPC, 2 = rs1, 3 = zero
- alu_src_b  out  2  0 = rs2, 1 = Imm, 2 = constant 4
- alu_op  out  4  ALUOP_ADD, ALUOP_BRANCH, ALUOP_RTYPE or ALUOP_ITYPE
- result_src  out  2  0 = ALUOut register, 1 = load data, 2 = ALU result direct
- illegal  out  1  unsupported opcode trapped
- retired  out  CNT_W  count of completed instructions

## Operation
- Moore FSM; all control outputs decode from the state, except mem_req/ir_write/pc_write qualifiers noted below.
- Any output not listed for a state is 0.
- FETCH: mem_req=1, adr_src=0, alu_src_a=0, alu_src_b=2, alu_op=ADD, result_src=2. When mem_ready=1: ir_write=1, pc_write=1, go to DECODE. Otherwise hold.
- DECODE: alu_src_a=1, alu_src_b=1, alu_op=ADD (ALUOut = OldPC+Imm). Dispatch on opcode:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → EXEC_JALR
  - 0110111 → EXEC_LUI
  - 0010111 → EXEC_AUIPC
  - any other opcode → TRAP
- MEMADR: alu_src_a=2, alu_src_b=1, ADD. Go to MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, adr_src=1. When mem_ready=1 go to MEMWB.
- MEMWB: result_src=1, reg_write=1 → FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. When mem_ready=1 → FETCH.
- EXEC_R: alu_src_a=2, alu_src_b=0, RTYPE → ALUWB.
- EXEC_I: alu_src_a=2, alu_src_b=1, ITYPE → ALUWB.
- EXEC_LUI: alu_src_a=3, alu_src_b=1, ADD → ALUWB.
- EXEC_AUIPC: alu_src_a=1, alu_src_b=1, ADD → ALUWB.
- ALUWB: result_src=0, reg_write=1 → FETCH.
- BRANCH: alu_src_a=2, alu_src_b=0, alu_op=BRANCH, result_src=0, pc_write=branch_cond → FETCH.
- JAL: result_src=0, pc_write=1, alu_src_a=1, alu_src_b=2, ADD (ALUOut ← OldPC+4) → ALUWB.
- EXEC_JALR: alu_src_a=2, alu_src_b=1, ADD → JALR.
- JALR: result_src=0, pc_write=1, pc_lsb_clear=1, alu_src_a=1, alu_src_b=2, ADD → ALUWB.
- TRAP: illegal=1; the FSM stays in TRAP until reset, and no memory requests or writes are issued.
- retired increments by 1 on every transition into FETCH from any state other than FETCH. It wraps modulo 2^CNT_W.

## Timing
- Reset: the state register goes to FETCH and retired goes to 0. While reset=1, every output is 0, including mem_req. The first fetch request appears in the cycle after reset deasserts.
- Reset mid-instruction, including during a pending memory access, aborts the instruction with no register or PC write.
- Handshake:
  - mem_req stays asserted, with stable adr_src and mem_write, until the cycle mem_ready=1.
  - A transfer completes in that cycle, and the next state follows.
  - mem_ready while mem_req=0 is ignored.
- Cycles per instruction with mem_ready tied high:
  - R/I/LUI/AUIPC/JAL/store: 4
  - load: 5
  - branch: 3
  - JALR: 5
- Each cycle of mem_ready low adds one cycle in FETCH, MEMREAD or MEMWRITE.

## Structure
- Shared package mc_pkg: state enum, opcode constants, ALUOP_* codes, and the alu_src_a, alu_src_b and result_src encodings.
- The datapath and the decode logic import this package.
- One sub-module, retire_counter: CNT_W-bit counter with synchronous clear and increment enable.
- The FSM is a single always block for the state register plus combinational output decode.

## Test plan
- Reset held, then released with mem_ready=1 and an R-type instruction (opcode 0110011) on opcode. Required:
  - all outputs 0 during reset
  - FETCH → DECODE → EXEC_R → ALUWB, with reg_write=1 in cycle 4
  - retired=1 on entering the next FETCH
- Load (0000011) with mem_ready low for 3 cycles in MEMREAD. Required: mem_req=1 and adr_src=1 held throughout, MEMWB is reached 4 cycles after entering MEMREAD, and the load takes 8 cycles total.
- Branch (1100011):
  - with branch_cond=1: pc_write=1 in cycle 3
  - with branch_cond=0: pc_write=0 in cycle 3
  - both cases return to FETCH after 3 cycles
- JALR (1100111). Required:
  - pc_write=1 with pc_lsb_clear=1 in the JALR state
  - reg_write=1 with result_src=0 in the following ALUWB
  - 5 cycles total
- Opcode 1111111. Required: TRAP entered after DECODE, illegal=1, mem_req stays 0 for 10 cycles, and reset returns the FSM to FETCH with illegal=0.
- Reset asserted during MEMWRITE with mem_ready=0. Required: mem_write drops in the same cycle, no store completes, and retired=0. Also preload retired to 2^CNT_W−1 with a small CNT_W and check that it wraps to 0.
